// File: rtl/sonar_serial_rx.sv
// sonar_serial_rx: receives the sonar's 7O1 asynchronous serial stream and
// parses "AAA,DDDD#" frames. The last complete frame is presented as BCD
// angle and distance, with a one-cycle frame strobe and error strobe.
module sonar_serial_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        rx,
    output logic [11:0] angulo,
    output logic [15:0] distancia,
    output logic        frame_valido,
    output logic        erro,
    output logic [3:0]  db_estado,
    output logic [3:0]  db_indice
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV + 1);

    // Counter values at which a sample is taken: the counter starts at 0 in
    // the first cycle of a state, so a sample N cycles later is at N-1.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);

    localparam logic [3:0] OCIOSO   = 4'd0;
    localparam logic [3:0] INICIO   = 4'd1;
    localparam logic [3:0] DADOS    = 4'd2;
    localparam logic [3:0] PARIDADE = 4'd3;
    localparam logic [3:0] PARADA   = 4'd4;
    localparam logic [3:0] ENTREGA  = 4'd5;
    localparam logic [3:0] FALHA    = 4'd6;

    logic             rx_meta_reg;
    logic             rxs_reg;

    logic [3:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [6:0]       data_reg, data_next;
    logic             parity_reg, parity_next;

    logic [3:0]       index_reg;
    logic             frame_valido_reg;
    logic             erro_reg;
    logic [11:0]      angulo_reg;
    logic [15:0]      distancia_reg;

    logic             is_digit;
    logic             char_ok;
    logic             char_take;
    logic             shadow_clear;
    logic [27:0]      shadow_bus;

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rxs_reg     <= rx_meta_reg;
        end
    end

    // Bit-receiver next-state logic: mid-bit sampling driven by the baud counter
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + CNT_W'(1);
        bit_next    = bit_reg;
        data_next   = data_reg;
        parity_next = parity_reg;
        case (state_reg)
            OCIOSO: begin
                cnt_next = '0;
                if (!rxs_reg) begin
                    state_next = INICIO;
                end
            end
            INICIO: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next = '0;
                    bit_next = 3'd0;
                    // A line that is high again at mid-start was only a glitch
                    state_next = rxs_reg ? OCIOSO : DADOS;
                end
            end
            DADOS: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next  = '0;
                    data_next = {rxs_reg, data_reg[6:1]};
                    bit_next  = bit_reg + 3'd1;
                    if (bit_reg == 3'd6) begin
                        state_next = PARIDADE;
                    end
                end
            end
            PARIDADE: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next    = '0;
                    parity_next = rxs_reg;
                    state_next  = PARADA;
                end
            end
            PARADA: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next = '0;
                    // Odd parity: data plus parity bit must hold an odd count of ones
                    if (rxs_reg && (^{data_reg, parity_reg})) begin
                        state_next = ENTREGA;
                    end else begin
                        state_next = FALHA;
                    end
                end
            end
            ENTREGA, FALHA: begin
                cnt_next   = '0;
                state_next = OCIOSO;
            end
            default: begin
                cnt_next   = '0;
                state_next = OCIOSO;
            end
        endcase
    end

    // Bit-receiver state registers; ligar=0 parks the receiver in ocioso
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg  <= OCIOSO;
            cnt_reg    <= '0;
            bit_reg    <= 3'd0;
            data_reg   <= 7'd0;
            parity_reg <= 1'b0;
        end else if (!ligar) begin
            state_reg  <= OCIOSO;
            cnt_reg    <= '0;
            bit_reg    <= 3'd0;
            data_reg   <= data_reg;
            parity_reg <= parity_reg;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bit_reg    <= bit_next;
            data_reg   <= data_next;
            parity_reg <= parity_next;
        end
    end

    // Character classification against what the current frame position expects
    always_comb begin
        is_digit = (data_reg[6:4] == 3'b011) && (data_reg[3:0] <= 4'd9);
        case (index_reg)
            4'd3:    char_ok = (data_reg == 7'h2C);
            4'd8:    char_ok = (data_reg == 7'h23);
            default: char_ok = is_digit;
        endcase
        char_take    = ligar && (state_reg == ENTREGA) && char_ok;
        shadow_clear = !ligar || (state_reg == FALHA) ||
                       ((state_reg == ENTREGA) && !char_ok);
    end

    // Shadow digits: digit gi captures the frame character at position POS
    // (positions 0..2 angle, 4..7 distance); digit 0 is the angle MSD.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_digit
            localparam logic [3:0] POS = (gi < 3) ? 4'(gi) : 4'(gi + 1);
            logic [3:0] digit_reg;

            // Load on an accepted digit at this position, drop on any error
            always_ff @(posedge clock) begin
                if (!reset || shadow_clear) begin
                    digit_reg <= 4'd0;
                end else if (char_take && (index_reg == POS)) begin
                    digit_reg <= data_reg[3:0];
                end
            end

            assign shadow_bus[27 - 4*gi -: 4] = digit_reg;
        end
    endgenerate

    // Frame parser: walks the index, commits shadows on '#', pulses strobes
    always_ff @(posedge clock) begin
        if (!reset) begin
            index_reg        <= 4'd0;
            frame_valido_reg <= 1'b0;
            erro_reg         <= 1'b0;
            angulo_reg       <= 12'd0;
            distancia_reg    <= 16'd0;
        end else begin
            frame_valido_reg <= 1'b0;
            erro_reg         <= 1'b0;
            if (!ligar) begin
                index_reg <= 4'd0;
            end else if (state_reg == FALHA) begin
                erro_reg  <= 1'b1;
                index_reg <= 4'd0;
            end else if (state_reg == ENTREGA) begin
                if (!char_ok) begin
                    erro_reg  <= 1'b1;
                    index_reg <= 4'd0;
                end else if (index_reg == 4'd8) begin
                    frame_valido_reg <= 1'b1;
                    index_reg        <= 4'd0;
                    angulo_reg       <= shadow_bus[27:16];
                    distancia_reg    <= shadow_bus[15:0];
                end else begin
                    index_reg <= index_reg + 4'd1;
                end
            end
        end
    end

    assign angulo       = angulo_reg;
    assign distancia    = distancia_reg;
    assign frame_valido = frame_valido_reg;
    assign erro         = erro_reg;
    assign db_estado    = state_reg;
    assign db_indice    = index_reg;

endmodule
